// File: rtl/sym_vn_rank_lut.sv
// Four-read-port, two-bank LUT memory for the symmetric VN IB lookup with one shared dual-bank write port.
// Optional macro SYM_VN_ADDR_PIPE_EN adds a registered address stage (read latency 2 instead of 1).
module sym_vn_rank_lut #(
    parameter int QUAN_SIZE       = 3,
    parameter int LUT_PORT_SIZE   = 3,
    parameter int ENTRY_ADDR      = 5,
    parameter int MULTI_FRAME_NUM = 2,
    localparam int PW             = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM)
) (
    input  logic                     read_clk,
    input  logic                     rstn,
    input  logic [LUT_PORT_SIZE-2:0] y0_in_A,
    input  logic [LUT_PORT_SIZE-2:0] y0_in_B,
    input  logic [LUT_PORT_SIZE-2:0] y0_in_C,
    input  logic [LUT_PORT_SIZE-2:0] y0_in_D,
    input  logic [QUAN_SIZE-1:0]     y1_in_A,
    input  logic [QUAN_SIZE-1:0]     y1_in_B,
    input  logic [QUAN_SIZE-1:0]     y1_in_C,
    input  logic [QUAN_SIZE-1:0]     y1_in_D,
    input  logic                     read_addr_offset,
    output logic [LUT_PORT_SIZE-1:0] lut_data0,
    output logic [LUT_PORT_SIZE-1:0] lut_data1,
    output logic [LUT_PORT_SIZE-1:0] lut_data2,
    output logic [LUT_PORT_SIZE-1:0] lut_data3,
    output logic                     bank_addr_A,
    output logic                     bank_addr_B,
    output logic                     bank_addr_C,
    output logic                     bank_addr_D,
    output logic [PW-1:0]            page_addr_A,
    output logic [PW-1:0]            page_addr_B,
    output logic [PW-1:0]            page_addr_C,
    output logic [PW-1:0]            page_addr_D,
    input  logic [LUT_PORT_SIZE-1:0] lut_in_bank0,
    input  logic [LUT_PORT_SIZE-1:0] lut_in_bank1,
    input  logic [PW-1:0]            page_write_addr,
    input  logic                     write_addr_offset,
    input  logic                     we
);

    localparam int DEPTH = 1 << (PW + 1);

    logic [LUT_PORT_SIZE-2:0] y0_s [4];
    logic [QUAN_SIZE-1:0]     y1_s [4];
    logic [ENTRY_ADDR-1:0]    entry_s [4];
    logic                     bank_s [4];
    logic [PW-1:0]            page_s [4];

    logic                     rd_bank_s [4];
    logic [PW-1:0]            rd_page_s [4];
    logic                     rd_off_s;

    logic [LUT_PORT_SIZE-1:0] mem0_q [DEPTH];
    logic [LUT_PORT_SIZE-1:0] mem1_q [DEPTH];
    logic                     wr_en_s;
    logic [PW:0]              wr_idx_s;

    logic [LUT_PORT_SIZE-1:0] lut_d [4];
    logic [LUT_PORT_SIZE-1:0] lut_q [4];

    assign y0_s[0] = y0_in_A;
    assign y0_s[1] = y0_in_B;
    assign y0_s[2] = y0_in_C;
    assign y0_s[3] = y0_in_D;
    assign y1_s[0] = y1_in_A;
    assign y1_s[1] = y1_in_B;
    assign y1_s[2] = y1_in_C;
    assign y1_s[3] = y1_in_D;

    // Entry address decode: the y1 LSB picks the bank, the remaining bits form the page.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            entry_s[i] = {y0_s[i], y1_s[i]};
            bank_s[i]  = entry_s[i][0];
            page_s[i]  = entry_s[i][ENTRY_ADDR-1:1];
        end
    end

`ifdef SYM_VN_ADDR_PIPE_EN
    logic          bank_d [4];
    logic          bank_q [4];
    logic [PW-1:0] page_d [4];
    logic [PW-1:0] page_q [4];
    logic          roff_d;
    logic          roff_q;

    // Next value of the address pipeline stage.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bank_d[i] = bank_s[i];
            page_d[i] = page_s[i];
        end
        roff_d = read_addr_offset;
    end

    // Address pipeline register.
    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                bank_q[i] <= 1'b0;
                page_q[i] <= {PW{1'b0}};
            end
            roff_q <= 1'b0;
        end else begin
            bank_q <= bank_d;
            page_q <= page_d;
            roff_q <= roff_d;
        end
    end

    // The memory is read with the registered address.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rd_bank_s[i] = bank_q[i];
            rd_page_s[i] = page_q[i];
        end
        rd_off_s = roff_q;
    end
`else
    // The memory is read straight from the decoded address.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rd_bank_s[i] = bank_s[i];
            rd_page_s[i] = page_s[i];
        end
        rd_off_s = read_addr_offset;
    end
`endif

    assign bank_addr_A = rd_bank_s[0];
    assign bank_addr_B = rd_bank_s[1];
    assign bank_addr_C = rd_bank_s[2];
    assign bank_addr_D = rd_bank_s[3];
    assign page_addr_A = rd_page_s[0];
    assign page_addr_B = rd_page_s[1];
    assign page_addr_C = rd_page_s[2];
    assign page_addr_D = rd_page_s[3];

    // Write qualification: writes are dropped while reset is asserted.
    always_comb begin
        wr_en_s  = we & rstn;
        wr_idx_s = {write_addr_offset, page_write_addr};
    end

    // Dual-bank storage; contents survive reset. Non-blocking update keeps same-edge reads on the old word.
    always_ff @(posedge read_clk) begin
        if (wr_en_s) begin
            mem0_q[wr_idx_s] <= lut_in_bank0;
            mem1_q[wr_idx_s] <= lut_in_bank1;
        end
    end

    // Asynchronous LUTRAM-style read mux for each port.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (rd_bank_s[i]) begin
                lut_d[i] = mem1_q[{rd_off_s, rd_page_s[i]}];
            end else begin
                lut_d[i] = mem0_q[{rd_off_s, rd_page_s[i]}];
            end
        end
    end

    // Registered read data.
    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                lut_q[i] <= {LUT_PORT_SIZE{1'b0}};
            end
        end else begin
            lut_q <= lut_d;
        end
    end

    assign lut_data0 = lut_q[0];
    assign lut_data1 = lut_q[1];
    assign lut_data2 = lut_q[2];
    assign lut_data3 = lut_q[3];

endmodule

// File: tb/tb_sym_vn_rank_lut.sv
// Directed self-checking bench for sym_vn_rank_lut (default parameters).
module tb_sym_vn_rank_lut;

`ifdef SYM_VN_ADDR_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       read_clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] y0_a = 2'b00, y0_b = 2'b00, y0_c = 2'b00, y0_d = 2'b00;
    logic [2:0] y1_a = 3'b000, y1_b = 3'b000, y1_c = 3'b000, y1_d = 3'b000;
    logic       read_addr_offset = 1'b0;
    logic [2:0] lut_data0, lut_data1, lut_data2, lut_data3;
    logic       bank_a, bank_b, bank_c, bank_d;
    logic [3:0] page_a, page_b, page_c, page_d;
    logic [2:0] lut_in_bank0 = 3'b000, lut_in_bank1 = 3'b000;
    logic [3:0] page_write_addr = 4'd0;
    logic       write_addr_offset = 1'b0;
    logic       we = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    sym_vn_rank_lut dut (
        .read_clk(read_clk), .rstn(rstn),
        .y0_in_A(y0_a), .y0_in_B(y0_b), .y0_in_C(y0_c), .y0_in_D(y0_d),
        .y1_in_A(y1_a), .y1_in_B(y1_b), .y1_in_C(y1_c), .y1_in_D(y1_d),
        .read_addr_offset(read_addr_offset),
        .lut_data0(lut_data0), .lut_data1(lut_data1), .lut_data2(lut_data2), .lut_data3(lut_data3),
        .bank_addr_A(bank_a), .bank_addr_B(bank_b), .bank_addr_C(bank_c), .bank_addr_D(bank_d),
        .page_addr_A(page_a), .page_addr_B(page_b), .page_addr_C(page_c), .page_addr_D(page_d),
        .lut_in_bank0(lut_in_bank0), .lut_in_bank1(lut_in_bank1),
        .page_write_addr(page_write_addr), .write_addr_offset(write_addr_offset), .we(we)
    );

    always #5 read_clk = ~read_clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge read_clk);
        #1;
    endtask

    task automatic wr(input logic off, input logic [3:0] pg, input logic [2:0] d0, input logic [2:0] d1);
        write_addr_offset = off;
        page_write_addr   = pg;
        lut_in_bank0      = d0;
        lut_in_bank1      = d1;
        we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic set_all(input logic [1:0] y0, input logic [2:0] y1);
        y0_a = y0; y0_b = y0; y0_c = y0; y0_d = y0;
        y1_a = y1; y1_b = y1; y1_c = y1; y1_d = y1;
    endtask

    initial begin
        // Reset with arbitrary addresses
        y0_a = 2'b11; y1_a = 3'b101; y0_b = 2'b01; y1_b = 3'b010;
        y0_c = 2'b10; y1_c = 3'b111; y0_d = 2'b00; y1_d = 3'b001;
        read_addr_offset = 1'b1;
        tick(); tick();
        check_val("rst_d0", {5'd0, lut_data0}, 8'd0);
        check_val("rst_d1", {5'd0, lut_data1}, 8'd0);
        check_val("rst_d2", {5'd0, lut_data2}, 8'd0);
        check_val("rst_d3", {5'd0, lut_data3}, 8'd0);
        rstn = 1'b1;
        read_addr_offset = 1'b0;

        // Fill offset 0: bank0 = p[2:0], bank1 = ~p[2:0]
        for (int p = 0; p < 16; p++) begin
            wr(1'b0, 4'(p), 3'(p), ~3'(p));
        end
        wr(1'b1, 4'd3, 3'b111, 3'b000);
        wr(1'b1, 4'd15, 3'b001, 3'b110);

        // Basic read on port A
        y0_a = 2'b10; y1_a = 3'b011;
        repeat (LAT) tick();
        check_val("fill_bank", {7'd0, bank_a}, 8'd1);
        check_val("fill_page", {4'd0, page_a}, 8'h09);
        check_val("fill_data", {5'd0, lut_data0}, 8'h06);

        // Frame select
        y0_a = 2'b00; y1_a = 3'b110; read_addr_offset = 1'b1;
        repeat (LAT) tick();
        check_val("frame_off1", {5'd0, lut_data0}, 8'h07);
        read_addr_offset = 1'b0;
        repeat (LAT) tick();
        check_val("frame_off0", {5'd0, lut_data0}, 8'h03);

        // Four distinct reads in one cycle
        y0_a = 2'b00; y1_a = 3'b001;
        y0_b = 2'b01; y1_b = 3'b100;
        y0_c = 2'b11; y1_c = 3'b111;
        y0_d = 2'b01; y1_d = 3'b011;
        repeat (LAT) tick();
        check_val("quad_a", {5'd0, lut_data0}, 8'h07);
        check_val("quad_b", {5'd0, lut_data1}, 8'h06);
        check_val("quad_c", {5'd0, lut_data2}, 8'h00);
        check_val("quad_d", {5'd0, lut_data3}, 8'h02);
        check_val("quad_page_b", {4'd0, page_b}, 8'h06);
        check_val("quad_bank_c", {7'd0, bank_c}, 8'd1);

        // All four at the same address
        set_all(2'b10, 3'b011);
        repeat (LAT) tick();
        check_val("same_a", {5'd0, lut_data0}, 8'h06);
        check_val("same_b", {5'd0, lut_data1}, 8'h06);
        check_val("same_c", {5'd0, lut_data2}, 8'h06);
        check_val("same_d", {5'd0, lut_data3}, 8'h06);

        // Collision: port B reads bank0 page 2 while it is rewritten
        y0_b = 2'b00; y1_b = 3'b100;
        repeat (LAT - 1) tick();
        write_addr_offset = 1'b0; page_write_addr = 4'd2;
        lut_in_bank0 = 3'b101; lut_in_bank1 = 3'b100; we = 1'b1;
        tick();
        we = 1'b0;
        check_val("coll_old", {5'd0, lut_data1}, 8'h02);
        tick();
        check_val("coll_new", {5'd0, lut_data1}, 8'h05);

        // Asynchronous reset mid-stream, with a write attempt that must be ignored
        rstn = 1'b0;
        #1;
        check_val("mid_rst_d0", {5'd0, lut_data0}, 8'd0);
        check_val("mid_rst_d1", {5'd0, lut_data1}, 8'd0);
        wr(1'b1, 4'd15, 3'b111, 3'b111);
        check_val("mid_rst_hold2", {5'd0, lut_data2}, 8'd0);
        check_val("mid_rst_hold3", {5'd0, lut_data3}, 8'd0);
        y0_a = 2'b11; y1_a = 3'b110;
        y0_b = 2'b11; y1_b = 3'b111;
        read_addr_offset = 1'b1;
        rstn = 1'b1;
        repeat (LAT) tick();
        check_val("post_rst_b0", {5'd0, lut_data0}, 8'h01);
        check_val("post_rst_b1", {5'd0, lut_data1}, 8'h06);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
